// File: rtl/ct_ciu_ctcq_pkg.sv
// Shared constants and encodings for the CTC/DVM request-queue controller.
package ct_ciu_ctcq_pkg;
  localparam int CTCQ_ENTRY = 8;
  localparam int CTCQ_IDW   = 3;
  localparam int TGT_NUM    = 6;

  typedef enum logic [2:0] {
    TGT_PIU0 = 3'd0,
    TGT_PIU1 = 3'd1,
    TGT_PIU2 = 3'd2,
    TGT_PIU3 = 3'd3,
    TGT_EBIU = 3'd4,
    TGT_L2C  = 3'd5
  } tgt_e;

  typedef enum logic {
    DISP_IDLE  = 1'b0,
    DISP_ISSUE = 1'b1
  } disp_state_e;
endpackage

// File: rtl/ct_ciu_ctcq_rr_arb.sv
// Rotating-priority picker: first set candidate at or after ptr, wrapping modulo ENTRY.
module ct_ciu_ctcq_rr_arb
  import ct_ciu_ctcq_pkg::*;
#(
  parameter int ENTRY = CTCQ_ENTRY,
  parameter int IDW   = CTCQ_IDW
) (
  input  logic [ENTRY-1:0] cand,
  input  logic [IDW-1:0]   ptr,
  output logic             vld,
  output logic [IDW-1:0]   id,
  output logic [ENTRY-1:0] onehot
);
  logic [IDW-1:0] idx;

  // Scanning from the farthest offset down lets the nearest candidate win last.
  always_comb begin
    vld = 1'b0;
    id  = '0;
    idx = '0;
    for (int i = ENTRY - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr) + i) % ENTRY);
      if (cand[idx]) begin
        vld = 1'b1;
        id  = idx;
      end
    end
  end

  assign onehot = vld ? (ENTRY'(1) << id) : '0;
endmodule

// File: rtl/gated_clk_cell.sv
// Latch-based clock gate; the enable is captured while clk_in is low so clk_out never glitches.
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);
  logic clk_en_bf_latch;
  logic clk_en;

  assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

  always_latch begin
    if (!clk_in) clk_en <= clk_en_bf_latch | pad_yy_icg_scan_en;
  end

  assign clk_out = clk_in & clk_en;
endmodule

// File: rtl/ct_ciu_ctcq_reqq_ctrl.sv
// CTC/DVM reqq controller: entry allocation, six per-target round-robin dispatchers,
// response-done decode and occupancy tracking.
module ct_ciu_ctcq_reqq_ctrl
  import ct_ciu_ctcq_pkg::*;
#(
  parameter int ENTRY = CTCQ_ENTRY,
  parameter int IDW   = CTCQ_IDW
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             ciu_icg_en,
  input  logic             pad_yy_icg_scan_en,
  input  logic             ctc_alloc_vld,
  output logic             ctc_alloc_grnt,
  output logic [IDW-1:0]   ctc_alloc_id,
  input  logic [ENTRY-1:0] reqq_vld_x,
  output logic [ENTRY-1:0] reqq_create_en_x,
  input  logic [ENTRY-1:0] reqq_piu0_vld_x,
  input  logic [ENTRY-1:0] reqq_piu0_aim_x,
  output logic [ENTRY-1:0] reqq_pop_piu0_en_x,
  output logic             piu0_req_vld,
  output logic [IDW-1:0]   piu0_req_id,
  input  logic             piu0_req_rdy,
  input  logic [ENTRY-1:0] reqq_piu1_vld_x,
  input  logic [ENTRY-1:0] reqq_piu1_aim_x,
  output logic [ENTRY-1:0] reqq_pop_piu1_en_x,
  output logic             piu1_req_vld,
  output logic [IDW-1:0]   piu1_req_id,
  input  logic             piu1_req_rdy,
  input  logic [ENTRY-1:0] reqq_piu2_vld_x,
  input  logic [ENTRY-1:0] reqq_piu2_aim_x,
  output logic [ENTRY-1:0] reqq_pop_piu2_en_x,
  output logic             piu2_req_vld,
  output logic [IDW-1:0]   piu2_req_id,
  input  logic             piu2_req_rdy,
  input  logic [ENTRY-1:0] reqq_piu3_vld_x,
  input  logic [ENTRY-1:0] reqq_piu3_aim_x,
  output logic [ENTRY-1:0] reqq_pop_piu3_en_x,
  output logic             piu3_req_vld,
  output logic [IDW-1:0]   piu3_req_id,
  input  logic             piu3_req_rdy,
  input  logic [ENTRY-1:0] reqq_ebiu_vld_x,
  input  logic [ENTRY-1:0] reqq_ebiu_aim_x,
  output logic [ENTRY-1:0] reqq_pop_ebiu_en_x,
  output logic             ebiu_req_vld,
  output logic [IDW-1:0]   ebiu_req_id,
  input  logic             ebiu_req_rdy,
  input  logic [ENTRY-1:0] reqq_l2c_vld_x,
  input  logic [ENTRY-1:0] reqq_l2c_aim_x,
  output logic [ENTRY-1:0] reqq_pop_l2c_en_x,
  output logic             l2c_req_vld,
  output logic [IDW-1:0]   l2c_req_id,
  input  logic             l2c_req_rdy,
  input  logic             resp_vld,
  input  logic [IDW-1:0]   resp_id,
  output logic [ENTRY-1:0] reqq_resp_done_x,
  output logic [IDW:0]     reqq_cnt,
  output logic             reqq_full,
  output logic             reqq_empty
);
  logic [ENTRY-1:0]   t_vld [TGT_NUM];
  logic [ENTRY-1:0]   t_aim [TGT_NUM];
  logic [ENTRY-1:0]   t_pop [TGT_NUM];
  logic [IDW-1:0]     t_id  [TGT_NUM];
  logic [TGT_NUM-1:0] t_rdy;
  logic [TGT_NUM-1:0] t_req;

  assign t_vld[TGT_PIU0] = reqq_piu0_vld_x;
  assign t_vld[TGT_PIU1] = reqq_piu1_vld_x;
  assign t_vld[TGT_PIU2] = reqq_piu2_vld_x;
  assign t_vld[TGT_PIU3] = reqq_piu3_vld_x;
  assign t_vld[TGT_EBIU] = reqq_ebiu_vld_x;
  assign t_vld[TGT_L2C]  = reqq_l2c_vld_x;
  assign t_aim[TGT_PIU0] = reqq_piu0_aim_x;
  assign t_aim[TGT_PIU1] = reqq_piu1_aim_x;
  assign t_aim[TGT_PIU2] = reqq_piu2_aim_x;
  assign t_aim[TGT_PIU3] = reqq_piu3_aim_x;
  assign t_aim[TGT_EBIU] = reqq_ebiu_aim_x;
  assign t_aim[TGT_L2C]  = reqq_l2c_aim_x;
  assign t_rdy = {l2c_req_rdy, ebiu_req_rdy, piu3_req_rdy, piu2_req_rdy, piu1_req_rdy, piu0_req_rdy};

  assign {l2c_req_vld, ebiu_req_vld, piu3_req_vld, piu2_req_vld, piu1_req_vld, piu0_req_vld} = t_req;
  assign piu0_req_id = t_id[TGT_PIU0];
  assign piu1_req_id = t_id[TGT_PIU1];
  assign piu2_req_id = t_id[TGT_PIU2];
  assign piu3_req_id = t_id[TGT_PIU3];
  assign ebiu_req_id = t_id[TGT_EBIU];
  assign l2c_req_id  = t_id[TGT_L2C];
  assign reqq_pop_piu0_en_x = t_pop[TGT_PIU0];
  assign reqq_pop_piu1_en_x = t_pop[TGT_PIU1];
  assign reqq_pop_piu2_en_x = t_pop[TGT_PIU2];
  assign reqq_pop_piu3_en_x = t_pop[TGT_PIU3];
  assign reqq_pop_ebiu_en_x = t_pop[TGT_EBIU];
  assign reqq_pop_l2c_en_x  = t_pop[TGT_L2C];

  for (genvar gi = 0; gi < TGT_NUM; gi++) begin : g_disp
    disp_state_e      state_reg, state_next;
    logic [IDW-1:0]   ptr_reg, ptr_next;
    logic [IDW-1:0]   id_reg, id_next;
    logic             pick_vld;
    logic [IDW-1:0]   pick_id;
    logic [ENTRY-1:0] pick_onehot;
    logic             disp_clk;
    logic             disp_clk_en;

    ct_ciu_ctcq_rr_arb #(.ENTRY(ENTRY), .IDW(IDW)) u_arb (
      .cand   (t_vld[gi]),
      .ptr    (ptr_reg),
      .vld    (pick_vld),
      .id     (pick_id),
      .onehot (pick_onehot)
    );

    assign disp_clk_en = (|t_vld[gi]) | (state_reg == DISP_ISSUE);

    gated_clk_cell u_disp_gated_clk (
      .clk_in             (forever_cpuclk),
      .global_en          (1'b1),
      .module_en          (ciu_icg_en),
      .local_en           (disp_clk_en),
      .external_en        (1'b0),
      .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
      .clk_out            (disp_clk)
    );

    always_ff @(posedge disp_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
        state_reg <= DISP_IDLE;
        ptr_reg   <= '0;
        id_reg    <= '0;
      end else begin
        state_reg <= state_next;
        ptr_reg   <= ptr_next;
        id_reg    <= id_next;
      end
    end

    // An unaddressed pick is popped straight away so it never occupies the issue slot.
    always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      id_next    = id_reg;
      t_pop[gi]  = '0;
      if (state_reg == DISP_IDLE) begin
        if (pick_vld) begin
          ptr_next = (pick_id == IDW'(ENTRY - 1)) ? '0 : pick_id + IDW'(1);
          if (t_aim[gi][pick_id]) begin
            id_next    = pick_id;
            state_next = DISP_ISSUE;
          end else begin
            t_pop[gi] = pick_onehot;
          end
        end
      end else if (t_rdy[gi]) begin
        t_pop[gi]  = ENTRY'(1) << id_reg;
        state_next = DISP_IDLE;
      end
    end

    assign t_req[gi] = (state_reg == DISP_ISSUE);
    assign t_id[gi]  = id_reg;
  end

  logic [IDW-1:0] free_id;
  always_comb begin
    free_id = '0;
    for (int i = ENTRY - 1; i >= 0; i--) begin
      if (!reqq_vld_x[i]) free_id = IDW'(i);
    end
  end

  assign ctc_alloc_grnt   = ctc_alloc_vld & ~reqq_full;
  assign ctc_alloc_id     = free_id;
  assign reqq_create_en_x = ctc_alloc_grnt ? (ENTRY'(1) << free_id) : '0;
  assign reqq_resp_done_x = resp_vld ? (ENTRY'(1) << resp_id) : '0;

  logic [ENTRY-1:0] prev_vld_reg;
  logic [IDW:0]     cnt_reg;
  logic             retire;
  logic             cnt_clk;
  logic             cnt_clk_en;

  assign retire     = |(prev_vld_reg & ~reqq_vld_x);
  assign cnt_clk_en = ctc_alloc_grnt | retire | (|(prev_vld_reg ^ reqq_vld_x));

  gated_clk_cell u_cnt_gated_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (1'b1),
    .module_en          (ciu_icg_en),
    .local_en           (cnt_clk_en),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (cnt_clk)
  );

  always_ff @(posedge cnt_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      prev_vld_reg <= '0;
      cnt_reg      <= '0;
    end else begin
      prev_vld_reg <= reqq_vld_x;
      if (ctc_alloc_grnt && !retire)      cnt_reg <= cnt_reg + (IDW+1)'(1);
      else if (retire && !ctc_alloc_grnt) cnt_reg <= cnt_reg - (IDW+1)'(1);
    end
  end

  assign reqq_cnt   = cnt_reg;
  assign reqq_full  = (cnt_reg == (IDW+1)'(ENTRY));
  assign reqq_empty = (cnt_reg == '0);
endmodule
